instr_encoder: RTL and testbench

Instruction encoder and program loader for the single-cycle MIPS-subset CPU. It is the inverse of the control decoders. It accepts one instruction at a time as a mnemonic code plus fields over a valid/ready handshake, packs each one into a 32-bit MIPS word, and writes the words to consecutive instruction-memory addresses. It sits between the bench/boot sequencer and the instruction memory write port, and flags illegal mnemonics and address overflow.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/instr_field_pack.sv | 36 +++
 rtl/instr_encoder.sv | 136 +++++++++++++
 tb/tb_instr_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-subset encodings: opcodes, functs, encoder mnemonics and FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        MN_LW   = 4'd0,
        MN_SW   = 4'd1,
        MN_J    = 4'd2,
        MN_JAL  = 4'd3,
        MN_BEQ  = 4'd4,
        MN_BNE  = 4'd5,
        MN_XORI = 4'd6,
        MN_ADDI = 4'd7,
        MN_ADD  = 4'd8,
        MN_SUB  = 4'd9,
        MN_SLT  = 4'd10,
        MN_JR   = 4'd11
    } mnem_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PAD  = 2'd2,
        S_DONE = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: mnemonic + fields -> 32-bit MIPS word, flags codes 12-15.
module instr_field_pack
    import mips_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            MN_LW:   word = {OP_LW,   rs, rt, imm};
            MN_SW:   word = {OP_SW,   rs, rt, imm};
            MN_BEQ:  word = {OP_BEQ,  rs, rt, imm};
            MN_BNE:  word = {OP_BNE,  rs, rt, imm};
            MN_XORI: word = {OP_XORI, rs, rt, imm};
            MN_ADDI: word = {OP_ADDI, rs, rt, imm};
            MN_J:    word = {OP_J,   target};
            MN_JAL:  word = {OP_JAL, target};
            MN_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            MN_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            MN_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            // JR ignores whatever arrives on rt/rd
            MN_JR:   word = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FN_JR};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader. Define INSTR_ENCODER_NOP_PAD_EN to append
// a NOP after the last instruction (branch-delay slot fill).
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        accept;

    instr_field_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    assign in_ready = (state_q == S_LOAD);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = (state_q == S_DONE);
        err_d       = err_q;
        // start wins over a same-cycle accept, which is simply dropped
        if (start) begin
            state_d = S_LOAD;
            addr_d  = BASE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        if (pack_illegal) begin
                            err_d = 1'b1;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr_q;
                            mem_wdata_d = pack_word;
                            addr_d      = addr_q + ADDR_W'(1);
                            if (addr_q == ADDR_MAX) err_d = 1'b1;
                        end
                        if (in_last) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
                            state_d = S_PAD;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
`ifdef INSTR_ENCODER_NOP_PAD_EN
                S_PAD: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = 32'h0000_0000;
                    addr_d      = addr_q + ADDR_W'(1);
                    if (addr_q == ADDR_MAX) err_d = 1'b1;
                    state_d     = S_DONE;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= BASE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == S_LOAD);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings plus hand-written corner sequences.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    logic        in_ready, mem_we, busy, done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    logic        rdy2, we2, busy2, done2, err2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
    );

    // Narrow-address copy sharing the same stimulus, used for the wrap/overflow case
    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy2),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wdata2), .busy(busy2), .done(done2), .err(err2)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                         input logic last);
        in_valid  = 1'b1;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int ea;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0;
        in_rd = '0; in_imm = '0; in_target = '0; in_last = 1'b0;

        tbl[0]  = '{4'd8,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221820, 1'b0}; // ADD
        tbl[1]  = '{4'd7,  5'd0,  5'd8,  5'd31, 16'h0005, 26'h0,       32'h20080005, 1'b0}; // ADDI
        tbl[2]  = '{4'd0,  5'd29, 5'd4,  5'd0,  16'hFFFC, 26'h0,       32'h8FA4FFFC, 1'b0}; // LW
        tbl[3]  = '{4'd2,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h10,      32'h08000010, 1'b0}; // J
        tbl[4]  = '{4'd11, 5'd31, 5'd7,  5'd9,  16'h1234, 26'h0,       32'h03E00008, 1'b0}; // JR
        tbl[5]  = '{4'd13, 5'd1,  5'd1,  5'd1,  16'h1111, 26'h0,       32'h00000000, 1'b1}; // illegal
        tbl[6]  = '{4'd1,  5'd2,  5'd3,  5'd0,  16'h0010, 26'h0,       32'hAC430010, 1'b0}; // SW
        tbl[7]  = '{4'd3,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF, 1'b0}; // JAL
        tbl[8]  = '{4'd4,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       32'h1022FFFF, 1'b0}; // BEQ
        tbl[9]  = '{4'd5,  5'd3,  5'd4,  5'd0,  16'h0002, 26'h0,       32'h14640002, 1'b0}; // BNE
        tbl[10] = '{4'd6,  5'd5,  5'd6,  5'd0,  16'hABCD, 26'h0,       32'h38A6ABCD, 1'b0}; // XORI
        tbl[11] = '{4'd9,  5'd4,  5'd5,  5'd6,  16'h0000, 26'h0,       32'h00853022, 1'b0}; // SUB
        tbl[12] = '{4'd10, 5'd7,  5'd8,  5'd9,  16'h0000, 26'h0,       32'h00E8482A, 1'b0}; // SLT

        step(); step();
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_we",    32'(mem_we),   0);
        chk("rst_addr",  32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata,     0);
        chk("rst_busy",  32'(busy),     0);
        chk("rst_done",  32'(done),     0);
        chk("rst_err",   32'(err),      0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", 32'(in_ready), 0);

        // table: back-to-back accepts, one write per legal entry
        pulse_start();
        chk("start_busy",  32'(busy),     1);
        chk("start_ready", 32'(in_ready), 1);
        ea = 0;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].tgt, 1'b0);
            step();
            if (tbl[i].ill) begin
                chk($sformatf("tbl%0d_we", i),  32'(mem_we), 0);
                chk($sformatf("tbl%0d_err", i), 32'(err),    1);
            end else begin
                chk($sformatf("tbl%0d_we", i),   32'(mem_we),   1);
                chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(ea));
                chk($sformatf("tbl%0d_data", i), mem_wdata,     tbl[i].exp);
                ea++;
            end
        end
        idle();
        step();
        chk("hold_we",    32'(mem_we),   0);
        chk("hold_addr",  32'(mem_addr), 32'(ea - 1));
        chk("hold_data",  mem_wdata,     32'h00E8482A);
        chk("sticky_err", 32'(err),      1);

        // in_last on the third op
        pulse_start();
        chk("restart_err", 32'(err), 0);
        drive(4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0); step();
        drive(4'd7, 5'd0, 5'd8, 5'd0, 16'h5, 26'h0, 1'b0); step();
        drive(4'd2, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1); step();
        idle();
        chk("last_we",    32'(mem_we),   1);
        chk("last_addr",  32'(mem_addr), 2);
        chk("last_data",  mem_wdata,     32'h08000010);
        chk("last_ready", 32'(in_ready), 0);
        chk("last_done0", 32'(done),     0);
        step();
`ifdef INSTR_ENCODER_NOP_PAD_EN
        chk("pad_we",    32'(mem_we),   1);
        chk("pad_addr",  32'(mem_addr), 3);
        chk("pad_data",  mem_wdata,     32'h0);
        chk("pad_done0", 32'(done),     0);
        step();
`endif
        chk("done_rise", 32'(done),   1);
        chk("done_we",   32'(mem_we), 0);
        step();
        chk("done_hold", 32'(done),   1);

        // start while in_valid mid-LOAD: accept dropped, err/done cleared
        pulse_start();
        chk("done_clr", 32'(done), 0);
        drive(4'd14, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0); step();
        chk("ill_err", 32'(err),    1);
        chk("ill_we",  32'(mem_we), 0);
        drive(4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0); step();
        chk("pre_addr", 32'(mem_addr), 0);
        start = 1'b1;
        drive(4'd6, 5'd5, 5'd6, 5'd0, 16'hABCD, 26'h0, 1'b0); step();
        start = 1'b0;
        chk("drop_we",  32'(mem_we), 0);
        chk("drop_err", 32'(err),    0);
        chk("drop_busy", 32'(busy),  1);
        drive(4'd9, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0); step();
        chk("after_drop_addr", 32'(mem_addr), 0);
        chk("after_drop_data", mem_wdata,     32'h00853022);
        idle();

        // illegal op carrying in_last still finishes the program
        pulse_start();
        drive(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1); step();
        idle();
        chk("ill_last_we",    32'(mem_we),   0);
        chk("ill_last_err",   32'(err),      1);
        chk("ill_last_ready", 32'(in_ready), 0);
        step();
`ifdef INSTR_ENCODER_NOP_PAD_EN
        chk("ill_pad_addr", 32'(mem_addr), 0);
        step();
`endif
        chk("ill_last_done", 32'(done), 1);

        // ADDR_W=2 copy: five writes wrap 0,1,2,3,0 and err rises on the addr-3 write
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            drive(4'd8, 5'(i), 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
            step();
            chk($sformatf("wrap%0d_we", i),   32'(we2),   1);
            chk($sformatf("wrap%0d_addr", i), 32'(addr2), 32'(i % 4));
            chk($sformatf("wrap%0d_err", i),  32'(err2),  (i >= 3) ? 32'd1 : 32'd0);
        end
        idle();

        // asynchronous reset mid-load
        pulse_start();
        drive(4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0); step();
        rst_n = 1'b0;
        #1;
        chk("arst_we",    32'(mem_we),   0);
        chk("arst_addr",  32'(mem_addr), 0);
        chk("arst_data",  mem_wdata,     0);
        chk("arst_busy",  32'(busy),     0);
        chk("arst_ready", 32'(in_ready), 0);
        chk("arst_err",   32'(err),      0);
        idle();
        step();
        rst_n = 1'b1;
        step();
        chk("arst_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
